// File: rtl/ysyx_24080014_lsu_if.sv
// Core-to-LSU request/response bundle. The core drives the master side and the LSU the slave side.
interface ysyx_24080014_lsu_if;
    logic        valid;
    logic        ReadWr;
    logic        StoreWr;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic        mem_ready;
    logic [31:0] rdata;
    logic        busy;
    logic        misalign;

    modport master (
        output valid, ReadWr, StoreWr, addr, funct3, wdata,
        input  mem_ready, rdata, busy, misalign
    );

    modport slave (
        input  valid, ReadWr, StoreWr, addr, funct3, wdata,
        output mem_ready, rdata, busy, misalign
    );
endinterface

// File: rtl/ysyx_24080014_lsu.sv
// Fixed-latency RV32I load/store unit backed by a private DEPTH-word array.
// Define YSYX_24080014_LSU_MISALIGN_CHK_EN to flag and suppress misaligned accesses instead of force-aligning them.
module ysyx_24080014_lsu #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 1024
) (
    input logic                clk,
    input logic                rst,
    ysyx_24080014_lsu_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q;
    logic [2:0]    funct3_q;
    logic [31:0]   wdata_q;
    logic          load_q, store_q;
    logic [31:0]   rdata_q;
    logic          misalign_q;
    logic [31:0]   mem_q [DEPTH];

    logic          accept, enter_resp, mem_we, misaligned;
    logic          sel_load, sel_store;
    logic [2:0]    sel_f3;
    logic [AW+1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlanes, word_r, load_val;
    logic [7:0]    byte_r;
    logic [15:0]   half_r;

    assign accept = (state_q == IDLE) && bus.valid && (bus.ReadWr || bus.StoreWr);

    // With LATENCY=1 RESP is entered straight from IDLE, so the live request must be decoded.
    assign sel_load  = (state_q == IDLE) ? bus.ReadWr                   : load_q;
    assign sel_store = (state_q == IDLE) ? (bus.StoreWr && !bus.ReadWr) : store_q;
    assign sel_f3    = (state_q == IDLE) ? bus.funct3                   : funct3_q;
    assign sel_addr  = (state_q == IDLE) ? bus.addr[AW+1:0]             : addr_q;
    assign sel_wdata = (state_q == IDLE) ? bus.wdata                    : wdata_q;
    assign lane      = sel_addr[1:0];
    assign idx       = sel_addr[AW+1:2];

    always_comb begin
        // NOTE: every output of this block is given a default first so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (LATENCY <= 1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 2);
                end
            end
            WAIT: if (cnt_q == 4'd0) begin
                state_d    = RESP;
                enter_resp = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef YSYX_24080014_LSU_MISALIGN_CHK_EN
    assign misaligned = ((sel_f3 == 3'd1 || (sel_load && sel_f3 == 3'd5)) && lane[0])
                      || (sel_f3 == 3'd2 && lane != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Halfword and word lanes ignore the low address bits, which force-aligns when unchecked.
    always_comb begin
        be     = 4'b0000;
        wlanes = sel_wdata;
        case (sel_f3)
            3'd0: begin be = 4'b0001 << lane; wlanes = {4{sel_wdata[7:0]}}; end
            3'd1: begin be = lane[1] ? 4'b1100 : 4'b0011; wlanes = {2{sel_wdata[15:0]}}; end
            3'd2: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign word_r = mem_q[idx];
    assign byte_r = 8'(word_r >> {lane, 3'b000});
    assign half_r = lane[1] ? word_r[31:16] : word_r[15:0];

    always_comb begin
        load_val = '0;
        if (!misaligned) begin
            case (sel_f3)
                3'd0: load_val = {{24{byte_r[7]}}, byte_r};
                3'd1: load_val = {{16{half_r[15]}}, half_r};
                3'd2: load_val = word_r;
                3'd4: load_val = {24'd0, byte_r};
                3'd5: load_val = {16'd0, half_r};
                default: load_val = '0;
            endcase
        end
    end

    assign mem_we = enter_resp && sel_store && !misaligned && !rst;

    // NOTE: the array has no reset; its contents must survive rst and a per-word reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q   <= bus.addr[AW+1:0];
                funct3_q <= bus.funct3;
                wdata_q  <= bus.wdata;
                load_q   <= bus.ReadWr;
                store_q  <= bus.StoreWr && !bus.ReadWr;
            end
            if (enter_resp && sel_load) rdata_q <= load_val;
            misalign_q <= enter_resp && misaligned;
        end
    end

    assign bus.mem_ready = (state_q == RESP);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rdata     = rdata_q;
    assign bus.misalign  = misalign_q;
endmodule

// File: doc/ysyx_24080014_lsu.md
YSYX_24080014_LSU -- requirements
Module: ysyx_24080014_lsu

Interface
REQ-001 SHALL provide parameter LATENCY, default 3, cycles from request acceptance to mem_ready (legal range 1..15).
REQ-002 SHALL provide parameter DEPTH, default 1024, number of 32-bit words in the internal data array (power of two).
REQ-003 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have valid, input, 1, request valid from the core.
REQ-006 SHALL have ReadWr, input, 1, load request.
REQ-007 SHALL have StoreWr, input, 1, store request.
REQ-008 SHALL have addr, input, 32, byte address.
REQ-009 SHALL have funct3, input, 3, access size and sign (RV32I load/store encoding).
REQ-010 SHALL have wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have mem_ready, output, 1, one-cycle completion pulse.
REQ-012 SHALL have rdata, output, 32, extended load result.
REQ-013 SHALL have busy, output, 1, high while a request is in flight.
REQ-014 SHALL have misalign, output, 1, misaligned-access flag, valid with mem_ready.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 In IDLE, SHALL accept a request on a rising edge when valid && (ReadWr || StoreWr), latching addr, funct3, wdata and the operation, and SHALL go to WAIT.
REQ-017 SHALL decrement a latency counter in WAIT and SHALL go to RESP so that mem_ready is high exactly LATENCY cycles after the acceptance edge; with LATENCY=1, SHALL go directly to RESP.
REQ-018 In RESP, SHALL drive mem_ready=1 for exactly one cycle, then return to IDLE.
REQ-019 SHALL ignore valid, ReadWr and StoreWr in WAIT and RESP; a request still held in IDLE after mem_ready is accepted as a new request, so the initiator deasserts valid after mem_ready.
REQ-020 When ReadWr and StoreWr are both high at acceptance, SHALL perform the load only; no write occurs.
REQ-021 SHALL form the word index as addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-022 Store: funct3 0/1/2 = SB/SH/SW; SHALL write byte lanes selected by addr[1:0] on the edge that enters RESP; other funct3 values write nothing.
REQ-023 Load: funct3 0/1/2/4/5 = LB/LH/LW/LBU/LHU; SHALL sign- or zero-extend the selected lanes; other funct3 values return 0.
REQ-024 SHALL update rdata on the edge entering RESP and hold it until the next load completes; stores SHALL leave rdata unchanged.
REQ-025 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-026 A load to the word written by the immediately preceding store SHALL return the new data.

Reset
REQ-027 rst SHALL immediately force IDLE, mem_ready=0, busy=0, misalign=0, rdata=0 and counter=0, regardless of clk.
REQ-028 rst during WAIT SHALL discard the pending request; a pending store SHALL NOT be written.
REQ-029 rst SHALL NOT clear the data array; initial array content is zero.

Configuration
REQ-030 YSYX_24080014_LSU_MISALIGN_CHK_EN defined: a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL set misalign=1 together with mem_ready, suppress the write, and return rdata=0.
REQ-031 YSYX_24080014_LSU_MISALIGN_CHK_EN undefined: misalign SHALL be tied to 0, and halfword/word accesses SHALL force-align by ignoring addr[0] or addr[1:0] respectively.

Verification
REQ-032 LATENCY=3: SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> mem_ready 3 cycles after each acceptance, rdata=0xDEADBEEF.
REQ-033 SB addr=0x13 wdata=0x80, then LB addr=0x13 -> rdata=0xFFFFFF80; LBU addr=0x13 -> rdata=0x00000080.
REQ-034 DEPTH=1024: SW addr=0x1000 wdata=0x12345678, then LW addr=0x0 -> rdata=0x12345678 (address wrap).
REQ-035 SW addr=0x20 accepted, rst pulsed 1 cycle later, then LW addr=0x20 -> rdata=0 with no mem_ready during reset.
REQ-036 Toggle valid/ReadWr during WAIT -> exactly one mem_ready per accepted request; ReadWr=StoreWr=1 -> load result returned and memory unchanged.
REQ-037 MISALIGN_CHK_EN defined: LW addr=0x22 -> misalign=1 with mem_ready and rdata=0; undefined: returns the word at 0x20 with misalign=0.
